// File: rtl/usr_seq_pkg.sv
// ============================================================================
//  Module      : usr_seq_pkg
//  Description : Shared types and encodings for the USR op sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_seq_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      SHR   = 2'd2,
      SHL   = 2'd3
   } op_e;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2,
      RESP   = 2'd3
   } state_e;

endpackage : usr_seq_pkg

`default_nettype wire

// File: rtl/usr_op_sequencer.sv
// ============================================================================
//  Module      : usr_op_sequencer
//  Description : Command-driven sequencer driving a universal shift register
//                and returning the captured result on a response channel.
//                Optional macro USR_SEQ_PERF_EN adds a shift-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_op_sequencer
   import usr_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  op_e              cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_cnt,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             usr_clr,
   output logic             usr_shift_en,
   output logic [1:0]       usr_sel,
   output logic [WIDTH-1:0] usr_data_in,
   input  logic [WIDTH-1:0] usr_out
`ifdef USR_SEQ_PERF_EN
   ,
   output logic [15:0]      perf_shift_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             usr_clr_q;
   logic             usr_shift_en_q;
   logic [1:0]       usr_sel_q;
   logic [WIDTH-1:0] usr_data_in_q;

   assign cmd_ready    = (state_q == IDLE);
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign usr_clr      = usr_clr_q;
   assign usr_shift_en = usr_shift_en_q;
   assign usr_sel      = usr_sel_q;
   assign usr_data_in  = usr_data_in_q;

   // Controls are set on the accept edge so they are live for the whole ISSUE
   // phase; CLEAR and LOAD reuse the down-counter with a count of one.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         usr_clr_q      <= 1'b1;
         usr_shift_en_q <= 1'b0;
         usr_sel_q      <= SEL_HOLD;
         usr_data_in_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               usr_clr_q <= 1'b0;
               if (cmd_valid) begin
                  case (cmd_op)
                     CLEAR: begin
                        usr_clr_q <= 1'b1;
                        cnt_q     <= CNT_ONE;
                        state_q   <= ISSUE;
                     end
                     LOAD: begin
                        usr_shift_en_q <= 1'b1;
                        usr_sel_q      <= SEL_LOAD;
                        usr_data_in_q  <= cmd_data;
                        cnt_q          <= CNT_ONE;
                        state_q        <= ISSUE;
                     end
                     SHR, SHL: begin
                        cnt_q <= cmd_cnt;
                        if (cmd_cnt == '0) begin
                           state_q <= SETTLE;
                        end else begin
                           usr_shift_en_q <= 1'b1;
                           usr_sel_q      <= (cmd_op == SHR) ? SEL_SHR : SEL_SHL;
                           state_q        <= ISSUE;
                        end
                     end
                  endcase
               end
            end
            ISSUE: begin
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  usr_clr_q      <= 1'b0;
                  usr_shift_en_q <= 1'b0;
                  usr_sel_q      <= SEL_HOLD;
                  usr_data_in_q  <= '0;
                  state_q        <= SETTLE;
               end
            end
            SETTLE: begin
               rsp_data_q  <= usr_out;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef USR_SEQ_PERF_EN
   logic [15:0] perf_q;
   logic [15:0] perf_d;

   always_comb begin
      perf_d = perf_q;
      if (usr_shift_en_q && (perf_q != 16'hFFFF)) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_shift_cnt = perf_q;
`endif

endmodule : usr_op_sequencer

`default_nettype wire
